// File: rtl/sci_host_if.sv
// Fabric-side byte streams and SCI register-bus control lines for sci_host.
// dbus is bidirectional and stays a plain port on the host module.
`timescale 1ns/1ps
interface sci_host_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic [1:0] rx_err;
    logic       rx_valid;
    logic       rx_ready;
    logic       cfg_done;
    logic       scisel;
    logic       rw;
    logic [1:0] addr;
    logic       sciirq;

    modport master (
        input  tx_data, tx_valid, rx_ready, sciirq,
        output tx_ready, rx_data, rx_err, rx_valid, cfg_done, scisel, rw, addr
    );

    modport slave (
        output tx_data, tx_valid, rx_ready, sciirq,
        input  tx_ready, rx_data, rx_err, rx_valid, cfg_done, scisel, rw, addr
    );
endinterface

// File: rtl/sci_host.sv
// Bus initiator for the uart SCI peripheral: programs SCCR once, polls SCSR,
// and moves bytes between RDR/TDR and one-byte rx/tx holding registers.
`timescale 1ns/1ps
module sci_host #(
    parameter logic [1:0] BAUDSEL  = 2'b00,
    parameter bit         IRQ_MODE = 1'b0
) (
    input  logic         clk,
    input  logic         rst,
    sci_host_if.master   bus,
    inout  wire  [7:0]   dbus
);

    typedef enum logic [2:0] {CFG, GAP, POLL, RD, WR} state_t;

    localparam logic [7:0] SCCR_VAL = {IRQ_MODE, IRQ_MODE, 4'b0000, BAUDSEL};

    state_t     state, state_n;
    logic       run;
    logic       cfg_done;
    logic       tx_full;
    logic [7:0] tx_buf;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic [1:0] rx_err;
    logic       st_tdre, st_rdrf, st_oe, st_fe;
    logic       scisel, rw;
    logic [1:0] addr;
    logic       drive;
    logic [7:0] drive_val;
    logic       tx_ready;
    logic       tx_fire;
    logic       rx_free;

    assign tx_ready = cfg_done & ~tx_full;
    assign tx_fire  = bus.tx_valid & tx_ready;
    assign rx_free  = ~rx_valid | bus.rx_ready;

    // run holds accesses off for the first cycle after reset so the bus is
    // idle while reset is applied and CFG is presented only once it is released.
    always_comb begin
        state_n   = state;
        scisel    = 1'b0;
        rw        = 1'b0;
        addr      = 2'b00;
        drive     = 1'b0;
        drive_val = '0;
        if (run) begin
            case (state)
                CFG: begin
                    scisel    = 1'b1;
                    rw        = 1'b1;
                    addr      = 2'b11;
                    drive     = 1'b1;
                    drive_val = SCCR_VAL;
                    state_n   = GAP;
                end
                GAP: begin
                    if (st_rdrf && rx_free)
                        state_n = RD;
                    else if (st_tdre && tx_full)
                        state_n = WR;
                    else if (!IRQ_MODE || bus.sciirq)
                        state_n = POLL;
                    else
                        state_n = GAP;
                end
                POLL: begin
                    scisel  = 1'b1;
                    addr    = 2'b01;
                    state_n = GAP;
                end
                RD: begin
                    scisel  = 1'b1;
                    addr    = 2'b00;
                    state_n = GAP;
                end
                WR: begin
                    scisel    = 1'b1;
                    rw        = 1'b1;
                    addr      = 2'b00;
                    drive     = 1'b1;
                    drive_val = tx_buf;
                    state_n   = GAP;
                end
                default: state_n = CFG;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= CFG;
            run      <= 1'b0;
            cfg_done <= 1'b0;
            tx_full  <= 1'b0;
            tx_buf   <= '0;
            rx_valid <= 1'b0;
            rx_data  <= '0;
            rx_err   <= '0;
            st_tdre  <= 1'b0;
            st_rdrf  <= 1'b0;
            st_oe    <= 1'b0;
            st_fe    <= 1'b0;
        end else begin
            run   <= 1'b1;
            state <= state_n;
            if (tx_fire) begin
                tx_buf  <= bus.tx_data;
                tx_full <= 1'b1;
            end
            if (rx_valid && bus.rx_ready)
                rx_valid <= 1'b0;
            if (run) begin
                case (state)
                    CFG:  cfg_done <= 1'b1;
                    POLL: begin
                        st_tdre <= dbus[7];
                        st_rdrf <= dbus[6];
                        st_oe   <= dbus[1];
                        st_fe   <= dbus[0];
                    end
                    RD: begin
                        rx_data  <= dbus;
                        rx_err   <= {st_oe, st_fe};
                        rx_valid <= 1'b1;
                        st_tdre  <= 1'b0;
                        st_rdrf  <= 1'b0;
                        st_oe    <= 1'b0;
                        st_fe    <= 1'b0;
                    end
                    WR: begin
                        tx_full <= 1'b0;
                        st_tdre <= 1'b0;
                        st_rdrf <= 1'b0;
                        st_oe   <= 1'b0;
                        st_fe   <= 1'b0;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign dbus         = drive ? drive_val : 'z;
    assign bus.scisel   = scisel;
    assign bus.rw       = rw;
    assign bus.addr     = addr;
    assign bus.tx_ready = tx_ready;
    assign bus.rx_valid = rx_valid;
    assign bus.rx_data  = rx_data;
    assign bus.rx_err   = rx_err;
    assign bus.cfg_done = cfg_done;

endmodule

// File: tb/tb_sci_host.sv
// Directed bench for sci_host: a small SCI register model answers bus reads,
// one instance polls continuously and a second runs in interrupt mode.
`timescale 1ns/1ps
module tb_sci_host;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sci_host_if ifa();
    sci_host_if ifb();
    wire [7:0] dbus_a;
    wire [7:0] dbus_b;

    sci_host #(.BAUDSEL(2'b10), .IRQ_MODE(1'b0)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (ifa),
        .dbus(dbus_a)
    );

    sci_host #(.BAUDSEL(2'b01), .IRQ_MODE(1'b1)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (ifb),
        .dbus(dbus_b)
    );

    // Peripheral register model for instance A
    logic       p_tdre, p_rdrf, p_oe, p_fe;
    logic [7:0] p_rdr, p_tdr;
    logic [7:0] rd_val_a;

    always_comb begin
        rd_val_a = 8'h00;
        if (ifa.addr == 2'b01)
            rd_val_a = {p_tdre, p_rdrf, 4'b0000, p_oe, p_fe};
        else if (ifa.addr == 2'b00)
            rd_val_a = p_rdr;
    end

    assign dbus_a = (ifa.scisel & ~ifa.rw) ? rd_val_a : 'z;
    assign dbus_b = (ifb.scisel & ~ifb.rw) ? 8'h00 : 'z;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;
    int unsigned n_rd    = 0;
    int unsigned n_wr    = 0;
    int unsigned n_poll_b = 0;
    logic [7:0]  hist[$];

    function automatic logic [7:0] acc_code(input logic sel, input logic w, input logic [1:0] a);
        if (!sel) return "-";
        if (w && a == 2'b11) return "C";
        if (!w && a == 2'b01) return "P";
        if (!w && a == 2'b00) return "R";
        if (w && a == 2'b00) return "W";
        return "?";
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; apply the peripheral side effects of the access that closed.
    task automatic tick();
        logic [7:0] ca, cb, wbyte;
        ca    = acc_code(ifa.scisel, ifa.rw, ifa.addr);
        cb    = acc_code(ifb.scisel, ifb.rw, ifb.addr);
        wbyte = dbus_a;
        @(posedge clk);
        #1;
        hist.push_back(ca);
        if (ca == "R") begin
            p_rdrf = 1'b0;
            p_oe   = 1'b0;
            p_fe   = 1'b0;
            n_rd++;
        end
        if (ca == "W") begin
            p_tdr  = wbyte;
            p_tdre = 1'b0;
            n_wr++;
        end
        if (cb == "P") n_poll_b++;
    endtask

    task automatic wait_acc_a(input logic [7:0] code, input int unsigned maxc, output bit found);
        int unsigned i;
        found = 1'b0;
        i = 0;
        while (!found && i <= maxc) begin
            if (acc_code(ifa.scisel, ifa.rw, ifa.addr) == code) found = 1'b1;
            else if (i < maxc) tick();
            i++;
        end
    endtask

    task automatic wait_rxv_a(input int unsigned maxc, output bit found);
        int unsigned i;
        found = 1'b0;
        i = 0;
        while (!found && i <= maxc) begin
            if (ifa.rx_valid) found = 1'b1;
            else if (i < maxc) tick();
            i++;
        end
    endtask

    initial begin
        bit found;
        int ir, iw, ip;
        int unsigned snap;

        rst = 1'b1;
        ifa.tx_data = '0; ifa.tx_valid = 1'b0; ifa.rx_ready = 1'b1; ifa.sciirq = 1'b0;
        ifb.tx_data = '0; ifb.tx_valid = 1'b0; ifb.rx_ready = 1'b1; ifb.sciirq = 1'b0;
        p_tdre = 1'b1; p_rdrf = 1'b0; p_oe = 1'b0; p_fe = 1'b0; p_rdr = '0; p_tdr = '0;

        tick();
        tick();
        chk("rst_scisel", ifa.scisel, 1'b0);
        chk("rst_rw", ifa.rw, 1'b0);
        chk("rst_addr", ifa.addr, 2'b00);
        chk("rst_tx_ready", ifa.tx_ready, 1'b0);
        chk("rst_rx_valid", ifa.rx_valid, 1'b0);
        chk("rst_rx_data", ifa.rx_data, 8'h00);
        chk("rst_rx_err", ifa.rx_err, 2'b00);
        chk("rst_cfg_done", ifa.cfg_done, 1'b0);
        chk("rst_scisel_b", ifb.scisel, 1'b0);

        // Startup: CFG, GAP, first POLL
        rst = 1'b0;
        tick();
        chk("cfg_access", acc_code(ifa.scisel, ifa.rw, ifa.addr), "C");
        chk("cfg_value", dbus_a, 8'h02);
        chk("cfg_done_during_cfg", ifa.cfg_done, 1'b0);
        chk("cfg_access_b", acc_code(ifb.scisel, ifb.rw, ifb.addr), "C");
        chk("cfg_value_b", dbus_b, 8'hC1);
        tick();
        chk("gap_scisel", ifa.scisel, 1'b0);
        chk("gap_cfg_done", ifa.cfg_done, 1'b1);
        chk("gap_tx_ready", ifa.tx_ready, 1'b1);
        tick();
        chk("first_poll", acc_code(ifa.scisel, ifa.rw, ifa.addr), "P");

        // Interrupt mode: silent without sciirq, polls once it rises
        n_poll_b = 0;
        repeat (50) tick();
        chk("irq_quiet_polls", n_poll_b, 0);
        ifb.sciirq = 1'b1;
        found = 1'b0;
        for (int k = 0; k <= 2 && !found; k++) begin
            if (acc_code(ifb.scisel, ifb.rw, ifb.addr) == "P") found = 1'b1;
            else if (k < 2) tick();
        end
        chk("irq_poll_seen", found, 1'b1);

        // Loopback of A5
        chk("lb_tx_ready", ifa.tx_ready, 1'b1);
        ifa.tx_data = 8'hA5; ifa.tx_valid = 1'b1;
        tick();
        ifa.tx_valid = 1'b0;
        chk("lb_tx_full", ifa.tx_ready, 1'b0);
        n_wr = 0;
        wait_acc_a("W", 4, found);
        chk("lb_wr_seen", found, 1'b1);
        chk("lb_wr_data", dbus_a, 8'hA5);
        tick();
        chk("lb_wr_count", n_wr, 1);
        p_tdre = 1'b1; p_rdr = p_tdr; p_rdrf = 1'b1;
        wait_rxv_a(4, found);
        chk("lb_rx_seen", found, 1'b1);
        chk("lb_rx_data", ifa.rx_data, 8'hA5);
        chk("lb_rx_err", ifa.rx_err, 2'b00);
        tick();

        // Back-pressure and overrun
        ifa.rx_ready = 1'b0;
        p_rdr = 8'h11; p_rdrf = 1'b1;
        wait_rxv_a(4, found);
        chk("bp_rx_seen", found, 1'b1);
        chk("bp_rx_data1", ifa.rx_data, 8'h11);
        chk("bp_rx_err1", ifa.rx_err, 2'b00);
        p_rdr = 8'h22; p_rdrf = 1'b1;
        n_rd = 0;
        repeat (10) tick();
        chk("bp_no_rd", n_rd, 0);
        chk("bp_held_valid", ifa.rx_valid, 1'b1);
        chk("bp_held_data", ifa.rx_data, 8'h11);
        p_oe = 1'b1;
        repeat (4) tick();
        ifa.rx_ready = 1'b1;
        tick();
        chk("bp_release_clear", ifa.rx_valid, 1'b0);
        wait_rxv_a(4, found);
        chk("bp_rx2_seen", found, 1'b1);
        chk("bp_rx_data2", ifa.rx_data, 8'h22);
        chk("bp_rx_err2", ifa.rx_err, 2'b10);
        tick();

        // RD before WR when both pending
        p_tdre = 1'b0;
        tick();
        tick();
        chk("pr_tx_ready", ifa.tx_ready, 1'b1);
        ifa.tx_data = 8'h77; ifa.tx_valid = 1'b1;
        tick();
        ifa.tx_valid = 1'b0;
        snap = n_wr;
        repeat (4) tick();
        chk("pr_no_wr_tdre0", n_wr, snap);
        hist.delete();
        p_tdre = 1'b1; p_rdr = 8'h5A; p_rdrf = 1'b1;
        repeat (12) tick();
        ir = -1; iw = -1; ip = -1;
        foreach (hist[i]) begin
            if (hist[i] == "R" && ir < 0) ir = i;
            if (hist[i] == "W" && iw < 0) iw = i;
            if (hist[i] == "P" && ir >= 0 && iw < 0 && ip < 0) ip = i;
        end
        chk("pr_rd_seen", ir >= 0, 1'b1);
        chk("pr_wr_seen", iw >= 0, 1'b1);
        chk("pr_rd_first", ir < iw, 1'b1);
        chk("pr_poll_between", ip > ir && ip < iw, 1'b1);
        chk("pr_rx_data", ifa.rx_data, 8'h5A);
        chk("pr_tdr", p_tdr, 8'h77);

        // Reset asserted during a WR access
        p_tdre = 1'b1;
        chk("mr_tx_ready", ifa.tx_ready, 1'b1);
        ifa.tx_data = 8'h99; ifa.tx_valid = 1'b1;
        tick();
        ifa.tx_valid = 1'b0;
        wait_acc_a("W", 4, found);
        chk("mr_wr_seen", found, 1'b1);
        rst = 1'b1;
        tick();
        chk("mr_scisel", ifa.scisel, 1'b0);
        chk("mr_tx_ready_low", ifa.tx_ready, 1'b0);
        chk("mr_cfg_done", ifa.cfg_done, 1'b0);
        chk("mr_rx_valid", ifa.rx_valid, 1'b0);
        rst = 1'b0;
        tick();
        chk("mr_cfg_again", acc_code(ifa.scisel, ifa.rw, ifa.addr), "C");
        chk("mr_cfg_value", dbus_a, 8'h02);
        tick();
        chk("mr_cfg_done_again", ifa.cfg_done, 1'b1);
        chk("mr_tx_discarded", ifa.tx_ready, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
